// File: rtl/sap1_control_core.sv
// SAP-1 control/execute core: instruction register, 6-step ring-counter sequencer and add/sub ALU.
// state | meaning: T1 PC->MAR | T2 PC++ | T3 RAM->IR | T4-T6 execute (HLT parks in T4)
module sap1_control_core (
  input  logic       clk,
  input  logic       n_clr,
  input  logic [7:0] wbus_in,
  input  logic [7:0] areg,
  input  logic [7:0] breg,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       cp,
  output logic       ep,
  output logic       n_lm,
  output logic       n_ce,
  output logic       n_li,
  output logic       n_ei,
  output logic       n_la,
  output logic       ea,
  output logic       su,
  output logic       eu,
  output logic       n_lb,
  output logic       n_lo,
  output logic       hlt,
  output logic [5:0] t_state,
  output logic [3:0] opcode
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_ir;
  logic [7:0] w_alu;
  logic       w_halt;

  assign opcode  = r_ir[7:4];
  assign t_state = r_state;
  assign w_halt  = (r_state == T4) && (r_ir[7:4] == OP_HLT);

  always_ff @(posedge clk or negedge n_clr) begin
    if (!n_clr) r_state <= T1;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge n_clr) begin
    if (!n_clr)     r_ir <= 8'h00;
    else if (!n_li) r_ir <= wbus_in;
  end

  always_comb begin
    w_next = T1;
    case (r_state)
      T1:      w_next = T2;
      T2:      w_next = T3;
      T3:      w_next = T4;
      T4:      w_next = w_halt ? T4 : T5;
      T5:      w_next = T6;
      T6:      w_next = T1;
      default: w_next = T1;
    endcase
  end

  always_comb begin
    cp   = 1'b0;
    ep   = 1'b0;
    n_lm = 1'b1;
    n_ce = 1'b1;
    n_li = 1'b1;
    n_ei = 1'b1;
    n_la = 1'b1;
    ea   = 1'b0;
    su   = 1'b0;
    eu   = 1'b0;
    n_lb = 1'b1;
    n_lo = 1'b1;
    hlt  = w_halt;
    case (r_state)
      T1: begin ep = 1'b1; n_lm = 1'b0; end
      T2: cp = 1'b1;
      T3: begin n_ce = 1'b0; n_li = 1'b0; end
      T4: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: begin n_ei = 1'b0; n_lm = 1'b0; end
          OP_OUT:                 begin ea = 1'b1; n_lo = 1'b0; end
          default: ;
        endcase
      end
      T5: begin
        case (opcode)
          OP_LDA:         begin n_ce = 1'b0; n_la = 1'b0; end
          OP_ADD, OP_SUB: begin n_ce = 1'b0; n_lb = 1'b0; end
          default: ;
        endcase
      end
      T6: begin
        case (opcode)
          OP_ADD: begin eu = 1'b1; n_la = 1'b0; end
          OP_SUB: begin eu = 1'b1; su = 1'b1; n_la = 1'b0; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Wraps modulo 256; SAP-1 has no carry or borrow flag.
  assign w_alu = su ? (areg - breg) : (areg + breg);

  always_comb begin
    bus_out = 8'h00;
    if (eu)         bus_out = w_alu;
    else if (!n_ei) bus_out = {4'h0, r_ir[3:0]};
  end

  assign bus_oe = eu | ~n_ei;

endmodule

// File: tb/tb_sap1_control_core.sv
// Directed bench for sap1_control_core; expected output snapshots go through a queue
// and are compared against the DUT once each step has settled.
module tb_sap1_control_core;

  logic       clk = 1'b0;
  logic       n_clr;
  logic [7:0] wbus_in, areg, breg, bus_out;
  logic       bus_oe, cp, ep, n_lm, n_ce, n_li, n_ei, n_la, ea, su, eu, n_lb, n_lo, hlt;
  logic [5:0] t_state;
  logic [3:0] opcode;

  typedef struct packed {
    logic [5:0] t;
    logic       hlt;
    logic       cp, ep, n_lm, n_ce, n_li, n_ei, n_la, ea, su, eu, n_lb, n_lo;
    logic       oe;
    logic [7:0] bus;
    logic [3:0] op;
  } outs_t;

  outs_t q_exp[$];
  outs_t e;
  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] cur_op;

  sap1_control_core dut (
    .clk(clk), .n_clr(n_clr), .wbus_in(wbus_in), .areg(areg), .breg(breg),
    .bus_out(bus_out), .bus_oe(bus_oe), .cp(cp), .ep(ep), .n_lm(n_lm),
    .n_ce(n_ce), .n_li(n_li), .n_ei(n_ei), .n_la(n_la), .ea(ea), .su(su),
    .eu(eu), .n_lb(n_lb), .n_lo(n_lo), .hlt(hlt), .t_state(t_state), .opcode(opcode)
  );

  always #5 clk = ~clk;

  function automatic outs_t idle(input logic [5:0] t, input logic [3:0] op);
    outs_t o;
    o = '0;
    o.t = t; o.op = op;
    o.n_lm = 1'b1; o.n_ce = 1'b1; o.n_li = 1'b1; o.n_ei = 1'b1;
    o.n_la = 1'b1; o.n_lb = 1'b1; o.n_lo = 1'b1;
    return o;
  endfunction

  function automatic outs_t sample();
    outs_t o;
    o.t = t_state; o.hlt = hlt; o.cp = cp; o.ep = ep; o.n_lm = n_lm; o.n_ce = n_ce;
    o.n_li = n_li; o.n_ei = n_ei; o.n_la = n_la; o.ea = ea; o.su = su; o.eu = eu;
    o.n_lb = n_lb; o.n_lo = n_lo; o.oe = bus_oe; o.bus = bus_out; o.op = opcode;
    return o;
  endfunction

  task automatic chk(input string tag, input outs_t exp_v);
    outs_t got, want;
    q_exp.push_back(exp_v);
    #1;
    got  = sample();
    want = q_exp.pop_front();
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h (t,hlt,ctrl12,oe,bus,op)", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fetch(input logic [7:0] ir, input string tag);
    e = idle(6'b000001, cur_op); e.ep = 1'b1; e.n_lm = 1'b0;
    chk({tag, "_T1"}, e); tick();
    e = idle(6'b000010, cur_op); e.cp = 1'b1;
    chk({tag, "_T2"}, e);
    wbus_in = ir; tick();
    e = idle(6'b000100, cur_op); e.n_ce = 1'b0; e.n_li = 1'b0;
    chk({tag, "_T3"}, e); tick();
    wbus_in = 8'h00;
    cur_op = ir[7:4];
  endtask

  initial begin
    n_clr = 1'b0; wbus_in = 8'h00; areg = 8'h00; breg = 8'h00; cur_op = 4'h0;
    tick(); tick();
    e = idle(6'b000001, 4'h0); e.ep = 1'b1; e.n_lm = 1'b0;
    chk("reset_hold", e);
    n_clr = 1'b1;

    // LDA 9
    fetch(8'h09, "lda");
    e = idle(6'b001000, 4'h0); e.n_ei = 1'b0; e.n_lm = 1'b0; e.oe = 1'b1; e.bus = 8'h09;
    chk("lda_T4", e); tick();
    e = idle(6'b010000, 4'h0); e.n_ce = 1'b0; e.n_la = 1'b0;
    chk("lda_T5", e); tick();
    e = idle(6'b100000, 4'h0);
    chk("lda_T6", e); tick();

    // ADD 5+3
    areg = 8'h05; breg = 8'h03;
    fetch(8'h1A, "add");
    e = idle(6'b001000, 4'h1); e.n_ei = 1'b0; e.n_lm = 1'b0; e.oe = 1'b1; e.bus = 8'h0A;
    chk("add_T4", e); tick();
    e = idle(6'b010000, 4'h1); e.n_ce = 1'b0; e.n_lb = 1'b0;
    chk("add_T5", e); tick();
    e = idle(6'b100000, 4'h1); e.eu = 1'b1; e.n_la = 1'b0; e.oe = 1'b1; e.bus = 8'h08;
    chk("add_T6", e); tick();

    // SUB 5-7 wraps to FE
    areg = 8'h05; breg = 8'h07;
    fetch(8'h2B, "sub");
    e = idle(6'b001000, 4'h2); e.n_ei = 1'b0; e.n_lm = 1'b0; e.oe = 1'b1; e.bus = 8'h0B;
    chk("sub_T4", e); tick();
    e = idle(6'b010000, 4'h2); e.n_ce = 1'b0; e.n_lb = 1'b0;
    chk("sub_T5", e); tick();
    e = idle(6'b100000, 4'h2); e.eu = 1'b1; e.su = 1'b1; e.n_la = 1'b0; e.oe = 1'b1; e.bus = 8'hFE;
    chk("sub_T6_wrap", e); tick();

    // ADD FF+01 wraps to 00
    areg = 8'hFF; breg = 8'h01;
    fetch(8'h13, "addw");
    e = idle(6'b001000, 4'h1); e.n_ei = 1'b0; e.n_lm = 1'b0; e.oe = 1'b1; e.bus = 8'h03;
    chk("addw_T4", e); tick(); tick();
    e = idle(6'b100000, 4'h1); e.eu = 1'b1; e.n_la = 1'b0; e.oe = 1'b1; e.bus = 8'h00;
    chk("addw_T6_wrap", e); tick();

    // OUT
    fetch(8'hE0, "out");
    e = idle(6'b001000, 4'hE); e.ea = 1'b1; e.n_lo = 1'b0;
    chk("out_T4", e); tick();
    e = idle(6'b010000, 4'hE);
    chk("out_T5", e); tick();
    e = idle(6'b100000, 4'hE);
    chk("out_T6", e); tick();

    // illegal opcode 5 behaves as NOP
    fetch(8'h57, "nop");
    e = idle(6'b001000, 4'h5);
    chk("nop_T4", e); tick();
    e = idle(6'b010000, 4'h5);
    chk("nop_T5", e); tick();
    e = idle(6'b100000, 4'h5);
    chk("nop_T6", e); tick();

    // reset asserted in the middle of T5
    areg = 8'h05; breg = 8'h03;
    fetch(8'h1A, "rst");
    tick();
    e = idle(6'b010000, 4'h1); e.n_ce = 1'b0; e.n_lb = 1'b0;
    chk("rst_T5", e);
    n_clr = 1'b0;
    e = idle(6'b000001, 4'h0); e.ep = 1'b1; e.n_lm = 1'b0;
    chk("rst_mid_T5", e);
    n_clr = 1'b1; cur_op = 4'h0;

    // HLT parks in T4 until reset
    fetch(8'hF0, "hlt");
    e = idle(6'b001000, 4'hF); e.hlt = 1'b1;
    chk("hlt_T4", e);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("hlt_hold%0d", i), e);
    end
    n_clr = 1'b0;
    e = idle(6'b000001, 4'h0); e.ep = 1'b1; e.n_lm = 1'b0;
    chk("hlt_clr", e);
    n_clr = 1'b1; cur_op = 4'h0;
    tick();
    e = idle(6'b000010, 4'h0); e.cp = 1'b1;
    chk("hlt_resume_T2", e);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
